ysyx_23060332_mem_arbiter: RTL and testbench



---
 rtl/ysyx_23060332_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_23060332_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_mem_arbiter
// Purpose  : N-master to 1-slave memory arbiter with valid/ready handshakes.
//            It allows one outstanding transaction at a time. Priority is
//            either fixed or round-robin. A response timeout returns an
//            error response instead of stalling the requesting master.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_mem_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int PRIO_MODE   = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req_valid,
  output logic [NUM_MASTERS-1:0]            m_req_ready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_req_addr,
  input  logic [NUM_MASTERS-1:0]            m_req_wen,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_req_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_req_wmask,
  output logic [NUM_MASTERS-1:0]            m_rsp_valid,
  output logic [DATA_W-1:0]                 m_rsp_rdata,
  output logic                              m_rsp_err,
  output logic                              s_req_valid,
  input  logic                              s_req_ready,
  output logic [ADDR_W-1:0]                 s_req_addr,
  output logic                              s_req_wen,
  output logic [DATA_W-1:0]                 s_req_wdata,
  output logic [DATA_W/8-1:0]               s_req_wmask,
  input  logic                              s_rsp_valid,
  input  logic [DATA_W-1:0]                 s_rsp_rdata,
  input  logic                              s_rsp_err
);

  localparam int c_IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int c_MASK_W = DATA_W / 8;
  // The counter has room above TIMEOUT, so it can saturate without wrapping back under the limit
  localparam int c_CNT_W  = $clog2(TIMEOUT + 2);

  localparam logic [c_IDX_W:0]   c_NM    = (c_IDX_W + 1)'(NUM_MASTERS);
  localparam logic [c_CNT_W-1:0] c_TO    = c_CNT_W'(TIMEOUT);
  localparam bit                 c_TO_EN = (TIMEOUT != 0);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_RSP  = 2'd3;

  logic [1:0]          r_state;
  logic [c_IDX_W-1:0]  r_grant;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_any;
  logic                w_accept;
  logic [c_IDX_W-1:0]  w_win;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_wen;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [c_MASK_W-1:0] w_sel_wmask;
  logic                w_rsp_take;
  logic                w_to_hit;

  assign w_any    = |m_req_valid;
  assign w_accept = (r_state == c_IDLE) && w_any;

  // The slave response wins over a timeout that expires in the same cycle
  assign w_rsp_take = (r_state == c_WAIT) && s_rsp_valid;
  assign w_to_hit   = (r_state == c_WAIT) && !s_rsp_valid && c_TO_EN && (r_cnt >= c_TO);

  generate
    if (PRIO_MODE == 0) begin : g_prio_fixed
      // Lowest requesting index wins
      always_comb begin
        w_win = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
          if (m_req_valid[i]) w_win = c_IDX_W'(i);
        end
      end
    end else begin : g_prio_rr
      logic [c_IDX_W-1:0]       r_rr_ptr;
      logic [2*NUM_MASTERS-1:0] w_dbl;
      logic [NUM_MASTERS-1:0]   w_rot;
      logic [c_IDX_W-1:0]       w_off;
      logic [c_IDX_W:0]         w_sum;
      logic [c_IDX_W:0]         w_inc;
      logic [c_IDX_W-1:0]       w_ptr_nxt;

      // Rotate the request vector so that the pointer position lands at bit 0
      assign w_dbl = {m_req_valid, m_req_valid};
      assign w_rot = w_dbl[r_rr_ptr +: NUM_MASTERS];

      // Distance from the pointer to the first requester at or after it
      always_comb begin
        w_off = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
          if (w_rot[i]) w_off = c_IDX_W'(i);
        end
      end

      assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
      assign w_win     = (w_sum >= c_NM) ? (w_sum[c_IDX_W-1:0] - c_NM[c_IDX_W-1:0])
                                         : w_sum[c_IDX_W-1:0];
      assign w_inc     = {1'b0, w_win} + {{c_IDX_W{1'b0}}, 1'b1};
      assign w_ptr_nxt = (w_inc >= c_NM) ? '0 : w_inc[c_IDX_W-1:0];

      // The pointer moves to one past the winner on every grant
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rr_ptr <= '0;
        end else if (w_accept) begin
          r_rr_ptr <= w_ptr_nxt;
        end
      end
    end
  endgenerate

  // Select the winner's request fields from the packed buses
  always_comb begin
    w_sel_addr  = m_req_addr[ADDR_W-1:0];
    w_sel_wen   = m_req_wen[0];
    w_sel_wdata = m_req_wdata[DATA_W-1:0];
    w_sel_wmask = m_req_wmask[c_MASK_W-1:0];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_win == c_IDX_W'(i)) begin
        w_sel_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wen   = m_req_wen[i];
        w_sel_wdata = m_req_wdata[i*DATA_W +: DATA_W];
        w_sel_wmask = m_req_wmask[i*c_MASK_W +: c_MASK_W];
      end
    end
  end

  // One-hot accept to the winner in IDLE, and one-hot response pulse in RSP
  always_comb begin
    m_req_ready = '0;
    m_rsp_valid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_req_ready[i] = w_accept && (w_win == c_IDX_W'(i));
      m_rsp_valid[i] = (r_state == c_RSP) && (r_grant == c_IDX_W'(i));
    end
  end

  // Transaction sequencing: IDLE -> REQ -> WAIT -> RSP -> IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      case (r_state)
        c_IDLE:  if (w_accept) r_state <= c_REQ;
        c_REQ:   if (s_req_ready) r_state <= c_WAIT;
        c_WAIT:  if (w_rsp_take || w_to_hit) r_state <= c_RSP;
        c_RSP:   r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Capture the granted request so it stays stable while the slave backpressures
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_accept) begin
      r_grant <= w_win;
      r_addr  <= w_sel_addr;
      r_wen   <= w_sel_wen;
      r_wdata <= w_sel_wdata;
      r_wmask <= w_sel_wmask;
    end
  end

  // Timeout counter: cleared on grant, counts through REQ and WAIT, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if ((r_state == c_REQ || r_state == c_WAIT) && (r_cnt != {c_CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Response data/error are held until the next response is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_rsp_take) begin
      r_rdata <= s_rsp_rdata;
      r_err   <= s_rsp_err;
    end else if (w_to_hit) begin
      r_rdata <= '0;
      r_err   <= 1'b1;
    end
  end

  assign s_req_valid = (r_state == c_REQ);
  assign s_req_addr  = r_addr;
  assign s_req_wen   = r_wen;
  assign s_req_wdata = r_wdata;
  assign s_req_wmask = r_wmask;
  assign m_rsp_rdata = r_rdata;
  assign m_rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_mem_arbiter
// Purpose  : Self-checking bench for the memory arbiter. Two instances, one
//            with fixed priority and one with round-robin priority, share the
//            same stimulus. They are checked against a transaction-level
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_mem_arbiter;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  logic [NM-1:0]    m_req_valid;
  logic [NM*AW-1:0] m_req_addr;
  logic [NM-1:0]    m_req_wen;
  logic [NM*DW-1:0] m_req_wdata;
  logic [NM*MW-1:0] m_req_wmask;
  logic             s_req_ready;
  logic             s_rsp_valid;
  logic [DW-1:0]    s_rsp_rdata;
  logic             s_rsp_err;

  logic [NM-1:0] fp_m_req_ready, rr_m_req_ready, fp_m_rsp_valid, rr_m_rsp_valid;
  logic [DW-1:0] fp_m_rsp_rdata, rr_m_rsp_rdata, fp_s_req_wdata, rr_s_req_wdata;
  logic          fp_m_rsp_err, rr_m_rsp_err, fp_s_req_valid, rr_s_req_valid;
  logic [AW-1:0] fp_s_req_addr, rr_s_req_addr;
  logic          fp_s_req_wen, rr_s_req_wen;
  logic [MW-1:0] fp_s_req_wmask, rr_s_req_wmask;

  // Per-master request fields held by the bench
  logic [AW-1:0] a_addr[NM];
  logic          a_wen[NM];
  logic [DW-1:0] a_wdata[NM];
  logic [MW-1:0] a_wmask[NM];

  int n_cmp = 0;
  int n_bad = 0;
  int rr_ptr = 0;

  always #5 clk = ~clk;

  ysyx_23060332_mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0), .TIMEOUT(TO)
  ) u_dut_fp (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(fp_m_req_ready),
    .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
    .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(fp_m_rsp_valid), .m_rsp_rdata(fp_m_rsp_rdata), .m_rsp_err(fp_m_rsp_err),
    .s_req_valid(fp_s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(fp_s_req_addr), .s_req_wen(fp_s_req_wen),
    .s_req_wdata(fp_s_req_wdata), .s_req_wmask(fp_s_req_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err)
  );

  ysyx_23060332_mem_arbiter #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1), .TIMEOUT(TO)
  ) u_dut_rr (
    .clk(clk), .rst(rst),
    .m_req_valid(m_req_valid), .m_req_ready(rr_m_req_ready),
    .m_req_addr(m_req_addr), .m_req_wen(m_req_wen),
    .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(rr_m_rsp_valid), .m_rsp_rdata(rr_m_rsp_rdata), .m_rsp_err(rr_m_rsp_err),
    .s_req_valid(rr_s_req_valid), .s_req_ready(s_req_ready),
    .s_req_addr(rr_s_req_addr), .s_req_wen(rr_s_req_wen),
    .s_req_wdata(rr_s_req_wdata), .s_req_wmask(rr_s_req_wmask),
    .s_rsp_valid(s_rsp_valid), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference priority rules
  function automatic int fp_pick(input logic [NM-1:0] m);
    for (int i = 0; i < NM; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int rr_pick(input logic [NM-1:0] m, input int p);
    for (int k = 0; k < NM; k++) if (m[(p + k) % NM]) return (p + k) % NM;
    return 0;
  endfunction

  task automatic rand_fields();
    for (int i = 0; i < NM; i++) begin
      a_addr[i]  = $urandom;
      a_wen[i]   = 1'($urandom);
      a_wdata[i] = {$urandom, $urandom};
      a_wmask[i] = 8'($urandom);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < NM; i++) begin
      m_req_addr[i*AW +: AW]  = a_addr[i];
      m_req_wen[i]            = a_wen[i];
      m_req_wdata[i*DW +: DW] = a_wdata[i];
      m_req_wmask[i*MW +: MW] = a_wmask[i];
    end
  endtask

  // One full transaction, entered and left at a falling edge with both DUTs idle.
  // rd = extra cycles the slave holds s_req_ready low; rspd = WAIT cycle index at
  // which the slave responds (beyond the deadline means the slave stays silent).
  task automatic txn(input logic [NM-1:0] mask, input int rd, input int rspd,
                     input logic serr, input logic [DW-1:0] sdata);
    int wf, wr, tk, endk;
    bit tmo;
    logic [AW-1:0] ea_f, ea_r;
    logic [DW-1:0] ed_f, ed_r, exp_data;
    logic [MW-1:0] em_f, em_r;
    logic          ew_f, ew_r, exp_err;
    m_req_valid = mask;
    pack_inputs();
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    #1;
    wf = fp_pick(mask);
    wr = rr_pick(mask, rr_ptr);
    chk("fp_grant", 64'(fp_m_req_ready), 64'(1) << wf);
    chk("rr_grant", 64'(rr_m_req_ready), 64'(1) << wr);
    ea_f = a_addr[wf];  ed_f = a_wdata[wf];  em_f = a_wmask[wf];  ew_f = a_wen[wf];
    ea_r = a_addr[wr];  ed_r = a_wdata[wr];  em_r = a_wmask[wr];  ew_r = a_wen[wr];
    @(posedge clk);
    rr_ptr = (wr + 1) % NM;
    @(negedge clk);
    // Scramble master inputs: the slave side must show the captured values
    m_req_valid = '0;
    rand_fields();
    pack_inputs();
    for (int c = 0; c <= rd; c++) begin
      chk("fp_s_valid", 64'(fp_s_req_valid), 64'(1));
      chk("rr_s_valid", 64'(rr_s_req_valid), 64'(1));
      chk("fp_s_addr", 64'(fp_s_req_addr), 64'(ea_f));
      chk("rr_s_addr", 64'(rr_s_req_addr), 64'(ea_r));
      chk("fp_s_wdata", fp_s_req_wdata, ed_f);
      chk("rr_s_wdata", rr_s_req_wdata, ed_r);
      chk("fp_s_wmask", 64'(fp_s_req_wmask), 64'(em_f));
      chk("rr_s_wmask", 64'(rr_s_req_wmask), 64'(em_r));
      chk("fp_s_wen", 64'(fp_s_req_wen), 64'(ew_f));
      chk("rr_s_wen", 64'(rr_s_req_wen), 64'(ew_r));
      chk("fp_busy_ready", 64'(fp_m_req_ready), 64'(0));
      s_rsp_valid = 1'($urandom);
      s_rsp_rdata = {$urandom, $urandom};
      s_rsp_err   = 1'($urandom);
      s_req_ready = (c == rd);
      @(negedge clk);
    end
    s_req_ready = 1'b0;
    // The deadline is the first WAIT cycle where cycles since grant reach TO
    tk   = (rd + 1 >= TO) ? 0 : TO - (rd + 1);
    tmo  = (rspd > tk);
    endk = tmo ? tk : rspd;
    for (int k = 0; k <= endk; k++) begin
      chk("fp_wait_s_valid", 64'(fp_s_req_valid), 64'(0));
      chk("rr_wait_s_valid", 64'(rr_s_req_valid), 64'(0));
      chk("fp_wait_rsp", 64'(fp_m_rsp_valid), 64'(0));
      chk("rr_wait_rsp", 64'(rr_m_rsp_valid), 64'(0));
      s_rsp_valid = (k == rspd);
      s_rsp_rdata = (k == rspd) ? sdata : {$urandom, $urandom};
      s_rsp_err   = (k == rspd) ? serr : 1'($urandom);
      @(negedge clk);
    end
    exp_data = tmo ? '0 : sdata;
    exp_err  = tmo ? 1'b1 : serr;
    chk("fp_rsp_valid", 64'(fp_m_rsp_valid), 64'(1) << wf);
    chk("rr_rsp_valid", 64'(rr_m_rsp_valid), 64'(1) << wr);
    chk("fp_rsp_data", fp_m_rsp_rdata, exp_data);
    chk("rr_rsp_data", rr_m_rsp_rdata, exp_data);
    chk("fp_rsp_err", 64'(fp_m_rsp_err), 64'(exp_err));
    chk("rr_rsp_err", 64'(rr_m_rsp_err), 64'(exp_err));
    // A stray slave response during RSP must be ignored
    s_rsp_valid = 1'($urandom);
    s_rsp_rdata = {$urandom, $urandom};
    s_rsp_err   = 1'($urandom);
    @(negedge clk);
    chk("fp_idle_rsp", 64'(fp_m_rsp_valid), 64'(0));
    chk("rr_idle_rsp", 64'(rr_m_rsp_valid), 64'(0));
    chk("fp_hold_data", fp_m_rsp_rdata, exp_data);
    chk("fp_hold_err", 64'(fp_m_rsp_err), 64'(exp_err));
    chk("rr_hold_data", rr_m_rsp_rdata, exp_data);
    chk("fp_idle_s_valid", 64'(fp_s_req_valid), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    m_req_valid = '0;
    s_req_ready = 1'b0;
    s_rsp_valid = 1'b0;
    s_rsp_rdata = '0;
    s_rsp_err   = 1'b0;
    rand_fields();
    pack_inputs();
    #1;
    chk("rst_fp_s_valid", 64'(fp_s_req_valid), 64'(0));
    chk("rst_rr_s_valid", 64'(rr_s_req_valid), 64'(0));
    chk("rst_fp_rsp_valid", 64'(fp_m_rsp_valid), 64'(0));
    chk("rst_fp_rdata", fp_m_rsp_rdata, 64'(0));
    chk("rst_fp_err", 64'(fp_m_rsp_err), 64'(0));
    chk("rst_fp_addr", 64'(fp_s_req_addr), 64'(0));
    chk("rst_fp_ready", 64'(fp_m_req_ready), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;

    // Idle cycles with stray slave responses: nothing may happen
    for (int i = 0; i < 3; i++) begin
      s_rsp_valid = 1'b1;
      s_rsp_rdata = {$urandom, $urandom};
      #1;
      chk("idle_fp_ready", 64'(fp_m_req_ready), 64'(0));
      @(negedge clk);
      chk("idle_fp_s_valid", 64'(fp_s_req_valid), 64'(0));
      chk("idle_rr_rsp", 64'(rr_m_rsp_valid), 64'(0));
    end

    // All masters request continuously: fixed stays on 0, round-robin cycles 0,1,2
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      txn(3'b111, 0, 0, 1'b0, {$urandom, $urandom});
    end

    // Single read from the LSU with a zero-wait slave
    rand_fields();
    a_addr[1] = 32'h8000_0010;
    a_wen[1]  = 1'b0;
    txn(3'b010, 0, 0, 1'b0, 64'h1122_3344_5566_7788);

    // IFU write with five cycles of slave backpressure
    rand_fields();
    a_wen[0]   = 1'b1;
    a_wdata[0] = 64'h0000_0000_DEAD_BEEF;
    a_wmask[0] = 8'h0F;
    txn(3'b001, 5, 1, 1'b0, {$urandom, $urandom});

    // Silent slave -> timeout; response in the deadline cycle beats the timeout
    rand_fields();
    txn(3'b001, 0, 100, 1'b0, 64'h0);
    rand_fields();
    txn(3'b010, 0, 7, 1'b1, 64'hCAFE_F00D_1234_5678);
    rand_fields();
    txn(3'b100, 0, 7, 1'b0, 64'h0BAD_C0DE_8765_4321);
    rand_fields();
    txn(3'b011, 9, 0, 1'b0, 64'h55AA_55AA_0F0F_F0F0);

    // Randomised traffic
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
          1'($urandom), {$urandom, $urandom});
    end

    // Reset while waiting on the slave aborts the transaction silently
    rand_fields();
    txn(3'b010, 0, 0, 1'b0, 64'hA5A5_5A5A_1357_9BDF);
    rand_fields();
    m_req_valid = 3'b001;
    pack_inputs();
    @(posedge clk);
    @(negedge clk);
    m_req_valid = '0;
    s_req_ready = 1'b1;
    @(negedge clk);
    s_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_fp_s_valid", 64'(fp_s_req_valid), 64'(0));
    chk("abort_rr_s_valid", 64'(rr_s_req_valid), 64'(0));
    chk("abort_fp_rdata", fp_m_rsp_rdata, 64'(0));
    chk("abort_rr_rdata", rr_m_rsp_rdata, 64'(0));
    chk("abort_fp_addr", 64'(fp_s_req_addr), 64'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_fp_rsp", 64'(fp_m_rsp_valid), 64'(0));
      chk("abort_rr_rsp", 64'(rr_m_rsp_valid), 64'(0));
    end
    rst = 1'b0;
    rr_ptr = 0;
    rand_fields();
    txn(3'b111, 0, 0, 1'b0, {$urandom, $urandom});
    rand_fields();
    txn(3'b110, 1, 2, 1'b0, {$urandom, $urandom});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
